datamemory_ls: RTL and testbench
================================

# datamemory_ls

Load/store data memory for the single-cycle core's successor datapath: byte-addressed, parametrised depth and access latency, with RISC-V sub-word loads/stores (byte/half/word, signed/unsigned), misalignment detection and a valid/ready request handshake with a registered response. It replaces the word-only, combinational-read data memory between the ALU address output and the write-back mux. It also serves as the memory stage for the multi-cycle and pipelined variants.

## Interface
- DM_ADDRESS, 9: word-address bits; storage is 2**DM_ADDRESS words.
- DATA_W, 32: word width; only 32 is legal (4 byte lanes).
- LATENCY, 1: cycles from request acceptance to response; legal 1..8.

- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- MemRead  in  1  load request (from control unit).
- MemWrite  in  1  store request (from control unit).
- funct3  in  3  access size: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
- a  in  DM_ADDRESS+2  byte address; a[DM_ADDRESS+1:2] word index, a[1:0] lane.
- wd  in  DATA_W  store data, right-aligned (byte in wd[7:0], half in wd[15:0]).
- rd  out  DATA_W  load result, extended to 32 bits.
- resp_valid  out  1  one-cycle response pulse for every accepted request.
- err  out  1  qualifies resp_valid: request was rejected.

## Operation
- Accept = req_valid & req_ready at a rising edge (edge E0). Inputs are sampled only at acceptance.
- States: IDLE, WAIT, RESP. req_ready = 1 in IDLE and RESP, 0 in WAIT.
- Accept with LATENCY=1: go to RESP. With LATENCY>1: go to WAIT, load counter with LATENCY-2.
- WAIT: counter reaches 0 -> RESP; else decrement.
- RESP: resp_valid=1 for exactly this cycle. Next state: if a new accept occurs, follow the accept rules; else IDLE.
- Error checks at acceptance; any error sets err=1 in the response, suppresses the write and forces rd=0:
  - MemRead & MemWrite both 1.
  - Neither MemRead nor MemWrite is 1.
  - funct3 not in {000,001,010,100,101} for loads; not in {000,001,010} for stores.
  - Half access with a[0]=1; word access with a[1:0]!=0.
- Store (no error): memory write occurs at E0, only to the enabled lanes.
  - sb: lane a[1:0] <= wd[7:0].
  - sh: lanes a[1]*2+{0,1} <= wd[15:0], little-endian.
  - sw: all 4 lanes.
  - Unselected lanes are unchanged. Response: err=0, rd=0.
- Load (no error): the word is read at E0, after any write committed at an earlier edge.
  - The lane(s) are selected by a[1:0].
  - 000/001 sign-extend; 100/101 zero-extend; 010 returns the full word.
  - The result is registered and presented in RESP.
- rd and err hold their last response value outside RESP; only resp_valid marks them valid.
- Memory array has no reset and is not initialised; reads of unwritten words are X in simulation.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, counter=0, req_ready=1, resp_valid=0, rd=0, err=0. Memory contents are preserved.
- Reset during WAIT or RESP: the pending response is dropped and never emitted. A store accepted before reset remains committed.
- resp_valid rises LATENCY edges after E0: at E0+1 for LATENCY=1, at E0+L for LATENCY=L.
- Throughput:
  - LATENCY=1: one request per cycle (RESP → RESP back-to-back).
  - LATENCY=L: one request per L cycles.
- Store then load to the same word on consecutive accepts: the load returns the new data. No forwarding hazard exists because the write commits at the store's acceptance edge.
- req_valid held high while req_ready=0: not accepted, no side effects. A requester may change its inputs while not accepted.

## Test plan
- Reset: assert rst_n=0 mid-WAIT (LATENCY=3) -> req_ready=1, resp_valid=0, rd=0, err=0 immediately; no response later.
- LATENCY=1, sw a=0x010 wd=0xDEADBEEF, next cycle lw a=0x010 -> two consecutive resp_valid pulses; second rd=0xDEADBEEF, err=0.
- Byte lanes: sw 0x00000000 to a=0x020, sb wd=0x80 at a=0x022 -> lw gives 0x00800000; lb a=0x022 gives 0xFFFFFF80; lbu gives 0x00000080.
- Halves: sh wd=0x1234ABCD at a=0x032 -> upper half 0xABCD; lh a=0x032 = 0xFFFFABCD; lhu = 0x0000ABCD; lower half unchanged.
- Errors: lh a=0x041, sw a=0x042, MemRead=MemWrite=1, funct3=011 load -> each gives resp_valid with err=1, rd=0; memory at those words unchanged on a later lw.
- LATENCY=3, req_valid held high with 4 back-to-back loads -> accepts spaced 3 cycles; resp_valid exactly 3 edges after each accept; req_ready low during the 2 WAIT cycles.

Source files
------------

// File: rtl/datamemory_ls.sv
`default_nettype none
// ============================================================================
// Module   : datamemory_ls
// Purpose  : Byte-addressed load/store data memory with RISC-V sub-word
//            accesses (lb/lh/lw/lbu/lhu, sb/sh/sw), misalignment and
//            illegal-request detection, a valid/ready request handshake and a
//            registered response delivered LATENCY cycles after acceptance.
// Ports    : clk, rst_n          - clock, async active-low reset
//            req_valid/req_ready - request handshake
//            MemRead, MemWrite   - load / store request qualifiers
//            funct3              - access size and sign selection
//            a                   - byte address (word index + lane)
//            wd                  - right-aligned store data
//            rd                  - extended load result (0 for stores/errors)
//            resp_valid, err     - one-cycle response pulse and its error flag
// Revision : 1.0 - initial release
// ============================================================================
module datamemory_ls #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            funct3,
    input  logic [DM_ADDRESS+1:0] a,
    input  logic [DATA_W-1:0]     wd,
    output logic [DATA_W-1:0]     rd,
    output logic                  resp_valid,
    output logic                  err
);

    localparam int c_DEPTH = 2 ** DM_ADDRESS;
    localparam int c_LANES = DATA_W / 8;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    // WAIT holds for LATENCY-1 cycles: counter runs LATENCY-2 .. 0.
    localparam logic [2:0] c_CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    logic [DATA_W-1:0]     r_mem [0:c_DEPTH-1];
    logic [1:0]            r_state;
    logic [2:0]            r_cnt;
    logic [DATA_W-1:0]     r_rd;
    logic                  r_err;
    logic [DATA_W-1:0]     r_pend_rd;
    logic                  r_pend_err;

    logic                  w_accept;
    logic                  w_is_load;
    logic                  w_is_store;
    logic                  w_f3_ok;
    logic                  w_misalign;
    logic                  w_err;
    logic                  w_we;
    logic [DM_ADDRESS-1:0] w_idx;
    logic [DATA_W-1:0]     w_word;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_W-1:0]     w_load_data;
    logic [DATA_W-1:0]     w_rd_new;
    logic [c_LANES-1:0]    w_be;
    logic [DATA_W-1:0]     w_wdata;

    assign req_ready  = (r_state != c_WAIT);
    assign resp_valid = (r_state == c_RESP);
    assign rd         = r_rd;
    assign err        = r_err;

    assign w_accept   = req_valid & req_ready;
    assign w_is_load  = MemRead & ~MemWrite;
    assign w_is_store = MemWrite & ~MemRead;
    assign w_idx      = a[DM_ADDRESS+1:2];
    assign w_word     = r_mem[w_idx];
    assign w_we       = w_accept & w_is_store & ~w_err;

    // Request legality: exactly one of read/write, a size code legal for
    // the direction, and natural alignment for half and word accesses.
    always_comb begin
        w_f3_ok = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
            3'b100, 3'b101:         w_f3_ok = w_is_load;
            default:                w_f3_ok = 1'b0;
        endcase
        w_misalign = ((funct3[1:0] == 2'b01) && a[0]) ||
                     ((funct3[1:0] == 2'b10) && (a[1:0] != 2'b00));
        w_err = ~(w_is_load | w_is_store) | ~w_f3_ok | w_misalign;
    end

    // Load lane selection and extension.
    always_comb begin
        w_byte      = w_word[{a[1:0], 3'b000} +: 8];
        w_half      = a[1] ? w_word[31:16] : w_word[15:0];
        w_load_data = '0;
        case (funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b010:  w_load_data = w_word;
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = '0;
        endcase
        // Stores and rejected requests always answer with zero.
        w_rd_new = (w_err || !w_is_load) ? '0 : w_load_data;
    end

    // Store lane enables; data is replicated so each lane picks its slice.
    always_comb begin
        w_be    = '0;
        w_wdata = wd;
        case (funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << a[1:0];
                w_wdata = {4{wd[7:0]}};
            end
            2'b01: begin
                w_be    = a[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wd[15:0]}};
            end
            2'b10: begin
                w_be    = 4'b1111;
                w_wdata = wd;
            end
            default: begin
                w_be    = '0;
                w_wdata = wd;
            end
        endcase
    end

    // Storage has no reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < c_LANES; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    // Control FSM. rd/err are only updated on entry to RESP so they keep the
    // previous response while a new request is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_cnt      <= 3'd0;
            r_rd       <= '0;
            r_err      <= 1'b0;
            r_pend_rd  <= '0;
            r_pend_err <= 1'b0;
        end else begin
            if (w_accept) begin
                if (LATENCY == 1) begin
                    r_state <= c_RESP;
                    r_rd    <= w_rd_new;
                    r_err   <= w_err;
                end else begin
                    r_state    <= c_WAIT;
                    r_cnt      <= c_CNT_INIT;
                    r_pend_rd  <= w_rd_new;
                    r_pend_err <= w_err;
                end
            end else begin
                case (r_state)
                    c_WAIT: begin
                        if (r_cnt == 3'd0) begin
                            r_state <= c_RESP;
                            r_rd    <= r_pend_rd;
                            r_err   <= r_pend_err;
                        end else begin
                            r_cnt <= r_cnt - 3'd1;
                        end
                    end
                    c_RESP:  r_state <= c_IDLE;
                    c_IDLE:  r_state <= c_IDLE;
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_datamemory_ls.sv
`default_nettype none
// ============================================================================
// Module   : tb_datamemory_ls
// Purpose  : Scoreboard bench for datamemory_ls. Instance 0 runs LATENCY=1,
//            instance 1 runs LATENCY=3. Drivers push expected responses
//            (data, err, arrival cycle) into a queue per instance; monitors
//            pop and compare on every resp_valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_datamemory_ls;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        rv   [2];
    logic        mr   [2];
    logic        mw   [2];
    logic [2:0]  f3   [2];
    logic [10:0] ad   [2];
    logic [31:0] wdd  [2];
    logic        rdy  [2];
    logic        rvld [2];
    logic        er   [2];
    logic [31:0] rdo  [2];

    exp_t q0[$];
    exp_t q1[$];
    int   cyc;
    int   tot;
    int   bad;
    int   acc1;
    bit   rdy_chk_en;
    int   acc_hist [4];

    datamemory_ls #(.DM_ADDRESS(9), .DATA_W(32), .LATENCY(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(rdy[0]),
        .MemRead(mr[0]), .MemWrite(mw[0]), .funct3(f3[0]), .a(ad[0]),
        .wd(wdd[0]), .rd(rdo[0]), .resp_valid(rvld[0]), .err(er[0])
    );

    datamemory_ls #(.DM_ADDRESS(9), .DATA_W(32), .LATENCY(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(rdy[1]),
        .MemRead(mr[1]), .MemWrite(mw[1]), .funct3(f3[1]), .a(ad[1]),
        .wd(wdd[1]), .rd(rdo[1]), .resp_valid(rvld[1]), .err(er[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Present a request and hold it until accepted; req_valid stays high
    // afterwards so consecutive calls are back-to-back.
    task automatic issue(input int d, input logic r, input logic w, input logic [2:0] f,
                         input logic [10:0] addr, input logic [31:0] data,
                         input logic [31:0] erd, input logic eerr, input bit push);
        exp_t e;
        int   n;
        rv[d]  = 1'b1;
        mr[d]  = r;
        mw[d]  = w;
        f3[d]  = f;
        ad[d]  = addr;
        wdd[d] = data;
        n = 0;
        @(negedge clk);
        while (!rdy[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[d]) begin
            tot++;
            bad++;
            $display("FAIL accept_timeout dut=%0d actual=not_ready required=ready", d);
            rv[d] = 1'b0;
            return;
        end
        if (push) begin
            e.rd  = erd;
            e.err = eerr;
            e.cyc = cyc + ((d == 0) ? 1 : 3);
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(posedge clk);
        #1;
        if (d == 1) acc1 = cyc;
    endtask

    task automatic idle(input int d, input int n);
        rv[d] = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rvld[0]) begin
            if (q0.size() == 0) begin
                tot++;
                bad++;
                $display("FAIL resp_unexpected dut=0 actual=pulse required=none");
            end else begin
                e = q0.pop_front();
                chk("rd_l1", rdo[0], e.rd);
                chk("err_l1", {31'd0, er[0]}, {31'd0, e.err});
                chk("cycle_l1", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rvld[1]) begin
            if (q1.size() == 0) begin
                tot++;
                bad++;
                $display("FAIL resp_unexpected dut=1 actual=pulse required=none");
            end else begin
                e = q1.pop_front();
                chk("rd_l3", rdo[1], e.rd);
                chk("err_l3", {31'd0, er[1]}, {31'd0, e.err});
                chk("cycle_l3", cyc, e.cyc);
            end
        end
    end

    // With LATENCY=3 the two cycles after an accept are WAIT (ready low).
    always @(negedge clk) begin
        if (rdy_chk_en) begin
            chk("ready_l3", {31'd0, rdy[1]},
                ((cyc - acc1) == 0 || (cyc - acc1) == 1) ? 32'd0 : 32'd1);
        end
    end

    initial begin
        cyc        = 0;
        tot        = 0;
        bad        = 0;
        acc1       = -100;
        rdy_chk_en = 1'b0;
        rst_n      = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; mr[i] = 1'b0; mw[i] = 1'b0;
            f3[i] = 3'd0; ad[i] = '0;   wdd[i] = '0;
        end
        #2 rst_n = 1'b0;
        #2;
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", {31'd0, rdy[i]}, 32'd1);
            chk("rst_valid", {31'd0, rvld[i]}, 32'd0);
            chk("rst_rd", rdo[i], 32'd0);
            chk("rst_err", {31'd0, er[i]}, 32'd0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(0, 1);

        // LATENCY=1 store then load, back-to-back
        issue(0, 0, 1, 3'b010, 11'h010, 32'hDEADBEEF, 32'h0, 0, 1);
        issue(0, 1, 0, 3'b010, 11'h010, 32'h0, 32'hDEADBEEF, 0, 1);

        // Byte lanes
        issue(0, 0, 1, 3'b010, 11'h020, 32'h00000000, 32'h0, 0, 1);
        issue(0, 0, 1, 3'b000, 11'h022, 32'h00000080, 32'h0, 0, 1);
        issue(0, 1, 0, 3'b010, 11'h020, 32'h0, 32'h00800000, 0, 1);
        issue(0, 1, 0, 3'b000, 11'h022, 32'h0, 32'hFFFFFF80, 0, 1);
        issue(0, 1, 0, 3'b100, 11'h022, 32'h0, 32'h00000080, 0, 1);

        // Halves
        issue(0, 0, 1, 3'b010, 11'h030, 32'h11112222, 32'h0, 0, 1);
        issue(0, 0, 1, 3'b001, 11'h032, 32'h1234ABCD, 32'h0, 0, 1);
        issue(0, 1, 0, 3'b010, 11'h030, 32'h0, 32'hABCD2222, 0, 1);
        issue(0, 1, 0, 3'b001, 11'h032, 32'h0, 32'hFFFFABCD, 0, 1);
        issue(0, 1, 0, 3'b101, 11'h032, 32'h0, 32'h0000ABCD, 0, 1);
        issue(0, 1, 0, 3'b101, 11'h030, 32'h0, 32'h00002222, 0, 1);

        // Errors: none may modify the word at 0x040
        issue(0, 0, 1, 3'b010, 11'h040, 32'h55667788, 32'h0, 0, 1);
        issue(0, 1, 0, 3'b001, 11'h041, 32'h0, 32'h0, 1, 1);
        issue(0, 0, 1, 3'b010, 11'h042, 32'hFFFFFFFF, 32'h0, 1, 1);
        issue(0, 1, 1, 3'b010, 11'h040, 32'h00000000, 32'h0, 1, 1);
        issue(0, 1, 0, 3'b011, 11'h040, 32'h0, 32'h0, 1, 1);
        issue(0, 0, 0, 3'b010, 11'h040, 32'h0, 32'h0, 1, 1);
        issue(0, 0, 1, 3'b100, 11'h040, 32'hFFFFFFFF, 32'h0, 1, 1);
        issue(0, 0, 1, 3'b001, 11'h043, 32'hFFFFFFFF, 32'h0, 1, 1);
        issue(0, 1, 0, 3'b010, 11'h040, 32'h0, 32'h55667788, 0, 1);
        idle(0, 3);

        // LATENCY=3: one store, then four loads with req_valid held high
        issue(1, 0, 1, 3'b010, 11'h100, 32'h8C7B6A59, 32'h0, 0, 1);
        idle(1, 6);
        rdy_chk_en = 1'b1;
        issue(1, 1, 0, 3'b010, 11'h100, 32'h0, 32'h8C7B6A59, 0, 1);
        acc_hist[0] = acc1;
        issue(1, 1, 0, 3'b000, 11'h103, 32'h0, 32'hFFFFFF8C, 0, 1);
        acc_hist[1] = acc1;
        issue(1, 1, 0, 3'b100, 11'h101, 32'h0, 32'h0000006A, 0, 1);
        acc_hist[2] = acc1;
        issue(1, 1, 0, 3'b001, 11'h102, 32'h0, 32'hFFFF8C7B, 0, 1);
        acc_hist[3] = acc1;
        idle(1, 4);
        rdy_chk_en = 1'b0;
        for (int i = 1; i < 4; i++) begin
            chk("accept_spacing", acc_hist[i] - acc_hist[i-1], 32'd3);
        end

        // Reset in the middle of WAIT: response must never appear
        issue(1, 1, 0, 3'b010, 11'h100, 32'h0, 32'h0, 0, 0);
        rv[1] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, rdy[1]}, 32'd1);
        chk("midrst_valid", {31'd0, rvld[1]}, 32'd0);
        chk("midrst_rd", rdo[1], 32'd0);
        chk("midrst_err", {31'd0, er[1]}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1, 8);

        // Memory survives reset
        issue(1, 1, 0, 3'b010, 11'h100, 32'h0, 32'h8C7B6A59, 0, 1);
        idle(1, 1);
        issue(0, 1, 0, 3'b010, 11'h010, 32'h0, 32'hDEADBEEF, 0, 1);
        idle(0, 8);

        chk("q_l1_empty", q0.size(), 32'd0);
        chk("q_l3_empty", q1.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
`default_nettype wire
